// File: rtl/simt_pc_pkg.sv
// simt_pc_pkg: core state encodings and the reconvergence stack entry shared by simt_pc and its stack
package simt_pc_pkg;
  localparam logic [2:0] CORE_STATE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_STATE_UPDATE = 3'b110;
  localparam int MAX_PC_BITS = 16;
  localparam int MAX_THREADS = 32;
  typedef struct packed {
    logic [MAX_PC_BITS-1:0] pend_pc;
    logic [MAX_THREADS-1:0] pend_mask;
    logic [MAX_THREADS-1:0] join_mask;
    logic                   pend_valid;
  } stack_entry_t;
endpackage

// File: rtl/simt_pc_if.sv
// simt_pc_if: decoder/ALU-side inputs (enable, thread_enable, core_state, decoded_*, alu_out, current_pc) and outputs (next_pc, active_mask, stack_count, stack_overflow) of simt_pc
interface simt_pc_if #(
  parameter int THREADS = 4,
  parameter int DATA_MEM_DATA_BITS = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int STACK_DEPTH = 4
);
  logic                                  enable;
  logic [THREADS-1:0]                    thread_enable;
  logic [2:0]                            core_state;
  logic [2:0]                            decoded_nzp;
  logic [DATA_MEM_DATA_BITS-1:0]         decoded_immediate;
  logic                                  decoded_nzp_write_enable;
  logic                                  decoded_pc_mux;
  logic                                  decoded_sync;
  logic [THREADS*DATA_MEM_DATA_BITS-1:0] alu_out;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]      current_pc;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]      next_pc;
  logic [THREADS-1:0]                    active_mask;
  logic [$clog2(STACK_DEPTH+1)-1:0]      stack_count;
  logic                                  stack_overflow;
  modport master (
    output enable, thread_enable, core_state, decoded_nzp, decoded_immediate,
           decoded_nzp_write_enable, decoded_pc_mux, decoded_sync, alu_out, current_pc,
    input  next_pc, active_mask, stack_count, stack_overflow
  );
  modport slave (
    input  enable, thread_enable, core_state, decoded_nzp, decoded_immediate,
           decoded_nzp_write_enable, decoded_pc_mux, decoded_sync, alu_out, current_pc,
    output next_pc, active_mask, stack_count, stack_overflow
  );
endinterface

// File: rtl/simt_pc_stack.sv
// simt_pc_stack: LIFO of reconvergence entries (push/pop/clear top pend_valid; ports clk, reset, en, push, pop, clr, push_entry -> top, count, full, empty)
module simt_pc_stack
  import simt_pc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clr,
  input  stack_entry_t                   push_entry,
  output stack_entry_t                   top,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  stack_entry_t mem_q [DEPTH];
  stack_entry_t mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d, tp;
  assign tp = cnt_q - CW'(1);
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign top = mem_q[tp[IW-1:0]];
  assign count = cnt_q;
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full) begin
      mem_d[cnt_q[IW-1:0]] = push_entry;
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) cnt_d = tp;
    else if (clr && !empty) mem_d[tp[IW-1:0]].pend_valid = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
    end else if (en) begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/simt_pc.sv
// simt_pc: warp PC with SIMT divergence/reconvergence (clk, reset, bus: simt_pc_if.slave); divergence stack enabled by SIMT_PC_DIVERGENCE_EN
module simt_pc
  import simt_pc_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int DATA_MEM_DATA_BITS = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int STACK_DEPTH = 4
) (
  input logic     clk,
  input logic     reset,
  simt_pc_if.slave bus
);
  localparam int A = PROGRAM_MEM_ADDR_BITS;
  localparam int D = DATA_MEM_DATA_BITS;
  logic [A-1:0] next_pc_q, next_pc_d, pc_inc, imm;
  logic [THREADS-1:0] mask_q, mask_d, eff, taken;
  logic [2:0] nzp_q [THREADS];
  logic [2:0] nzp_d [THREADS];
  logic exec, upd;
  assign eff = mask_q & bus.thread_enable;
  assign pc_inc = bus.current_pc + A'(1);
  assign imm = A'(bus.decoded_immediate);
  assign exec = bus.enable && bus.core_state == CORE_STATE_EXECUTE;
  assign upd = bus.enable && bus.core_state == CORE_STATE_UPDATE && bus.decoded_nzp_write_enable;
  assign bus.next_pc = next_pc_q;
  assign bus.active_mask = mask_q;
  always_comb begin
    for (int i = 0; i < THREADS; i++) begin
      taken[i] = eff[i] & |(nzp_q[i] & bus.decoded_nzp);
      nzp_d[i] = (upd && eff[i]) ? bus.alu_out[i*D +: 3] : nzp_q[i];
    end
  end
`ifdef SIMT_PC_DIVERGENCE_EN
  stack_entry_t top, push_e;
  logic push, pop, clr, full, empty, ovf_q, ovf_d;
  simt_pc_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .reset(reset), .en(bus.enable), .push(push), .pop(pop), .clr(clr),
    .push_entry(push_e), .top(top), .count(bus.stack_count), .full(full), .empty(empty)
  );
  assign bus.stack_overflow = ovf_q;
  always_comb begin
    push_e = '{pend_pc: MAX_PC_BITS'(pc_inc), pend_mask: MAX_THREADS'(eff & ~taken),
               join_mask: MAX_THREADS'(mask_q), pend_valid: 1'b1};
    next_pc_d = next_pc_q;
    mask_d = mask_q;
    ovf_d = ovf_q;
    push = 1'b0;
    pop = 1'b0;
    clr = 1'b0;
    if (exec) begin
      next_pc_d = pc_inc;
      if (bus.decoded_pc_mux) begin
        if (taken == eff) next_pc_d = imm;
        else if (|taken) begin
          if (full) ovf_d = 1'b1;
          else begin
            push = 1'b1;
            mask_d = taken;
            next_pc_d = imm;
          end
        end
      end else if (bus.decoded_sync && !empty) begin
        if (top.pend_valid) begin
          next_pc_d = top.pend_pc[A-1:0];
          mask_d = top.pend_mask[THREADS-1:0];
          clr = 1'b1;
        end else begin
          pop = 1'b1;
          mask_d = top.join_mask[THREADS-1:0];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else if (bus.enable) ovf_q <= ovf_d;
  end
`else
  assign bus.stack_count = '0;
  assign bus.stack_overflow = 1'b0;
  always_comb begin
    next_pc_d = exec ? ((bus.decoded_pc_mux && taken == eff && |eff) ? imm : pc_inc) : next_pc_q;
    mask_d = '1;
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc_q <= '0;
      mask_q <= '1;
      nzp_q <= '{default: 3'b000};
    end else if (bus.enable) begin
      next_pc_q <= next_pc_d;
      mask_q <= mask_d;
      nzp_q <= nzp_d;
    end
  end
endmodule

// File: tb/tb_simt_pc.sv
// tb_simt_pc: directed checks of simt_pc with stack depths 4 and 2 sharing one stimulus stream
module tb_simt_pc;
  import simt_pc_pkg::*;
`ifdef SIMT_PC_DIVERGENCE_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic [3:0] te = 4'hf;
  logic [2:0] cs = 3'b000, nzp = 3'b000;
  logic [7:0] imm = 8'h00, pc = 8'h00;
  logic we = 1'b0, mux = 1'b0, syncb = 1'b0;
  logic [31:0] alu = 32'h0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  simt_pc_if #(.STACK_DEPTH(4)) b4 ();
  simt_pc_if #(.STACK_DEPTH(2)) b2 ();
  assign b4.enable = enable;
  assign b4.thread_enable = te;
  assign b4.core_state = cs;
  assign b4.decoded_nzp = nzp;
  assign b4.decoded_immediate = imm;
  assign b4.decoded_nzp_write_enable = we;
  assign b4.decoded_pc_mux = mux;
  assign b4.decoded_sync = syncb;
  assign b4.alu_out = alu;
  assign b4.current_pc = pc;
  assign b2.enable = enable;
  assign b2.thread_enable = te;
  assign b2.core_state = cs;
  assign b2.decoded_nzp = nzp;
  assign b2.decoded_immediate = imm;
  assign b2.decoded_nzp_write_enable = we;
  assign b2.decoded_pc_mux = mux;
  assign b2.decoded_sync = syncb;
  assign b2.alu_out = alu;
  assign b2.current_pc = pc;
  simt_pc #(.STACK_DEPTH(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
  simt_pc #(.STACK_DEPTH(2)) u2 (.clk(clk), .reset(reset), .bus(b2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic st4(input string tag, input logic [7:0] p, input logic [3:0] m, input logic [2:0] c);
    chk({tag, "_pc"}, 32'(b4.next_pc), 32'(p));
    chk({tag, "_mask"}, 32'(b4.active_mask), 32'(m));
    chk({tag, "_cnt"}, 32'(b4.stack_count), 32'(c));
  endtask
  task automatic st2(input string tag, input logic [7:0] p, input logic [3:0] m, input logic [1:0] c, input logic o);
    chk({tag, "_pc2"}, 32'(b2.next_pc), 32'(p));
    chk({tag, "_mask2"}, 32'(b2.active_mask), 32'(m));
    chk({tag, "_cnt2"}, 32'(b2.stack_count), 32'(c));
    chk({tag, "_ovf2"}, 32'(b2.stack_overflow), 32'(o));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rst();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic set_nzp(input logic [31:0] a);
    cs = CORE_STATE_UPDATE;
    we = 1'b1;
    alu = a;
    tick();
    we = 1'b0;
    cs = 3'b000;
  endtask
  task automatic exe(input logic m, input logic s, input logic [2:0] n, input logic [7:0] i, input logic [7:0] p);
    cs = CORE_STATE_EXECUTE;
    mux = m;
    syncb = s;
    nzp = n;
    imm = i;
    pc = p;
    tick();
    mux = 1'b0;
    syncb = 1'b0;
    cs = 3'b000;
  endtask
  initial begin
    rst();
    st4("reset", 8'h00, 4'hf, 3'd0);
    st2("reset", 8'h00, 4'hf, 2'd0, 1'b0);
    set_nzp(32'h02020202);
    exe(1'b1, 1'b0, 3'b010, 8'h20, 8'h05);
    st4("uniform", 8'h20, 4'hf, 3'd0);
    exe(1'b0, 1'b0, 3'b000, 8'h00, 8'hff);
    st4("wrap", 8'h00, 4'hf, 3'd0);
    rst();
    set_nzp(32'h01010404);
    exe(1'b1, 1'b0, 3'b100, 8'h30, 8'h10);
    st4("diverge", DIV ? 8'h30 : 8'h11, DIV ? 4'h3 : 4'hf, DIV ? 3'd1 : 3'd0);
    enable = 1'b0;
    exe(1'b0, 1'b1, 3'b000, 8'h00, 8'h34);
    st4("hold", DIV ? 8'h30 : 8'h11, DIV ? 4'h3 : 4'hf, DIV ? 3'd1 : 3'd0);
    enable = 1'b1;
    exe(1'b0, 1'b1, 3'b000, 8'h00, 8'h34);
    st4("sync1", DIV ? 8'h11 : 8'h35, DIV ? 4'hc : 4'hf, DIV ? 3'd1 : 3'd0);
    exe(1'b0, 1'b1, 3'b000, 8'h00, 8'h34);
    st4("sync2", 8'h35, 4'hf, 3'd0);
    exe(1'b0, 1'b1, 3'b000, 8'h00, 8'h40);
    st4("sync_empty", 8'h41, 4'hf, 3'd0);
    rst();
    set_nzp(32'h00010204);
    exe(1'b1, 1'b0, 3'b111, 8'h40, 8'h00);
    st2("nest1", DIV ? 8'h40 : 8'h01, DIV ? 4'h7 : 4'hf, DIV ? 2'd1 : 2'd0, 1'b0);
    exe(1'b1, 1'b0, 3'b110, 8'h50, 8'h40);
    st2("nest2", DIV ? 8'h50 : 8'h41, DIV ? 4'h3 : 4'hf, DIV ? 2'd2 : 2'd0, 1'b0);
    exe(1'b1, 1'b0, 3'b100, 8'h60, 8'h50);
    st2("nest3", 8'h51, DIV ? 4'h3 : 4'hf, DIV ? 2'd2 : 2'd0, DIV);
    st4("nest3_d4", DIV ? 8'h60 : 8'h51, DIV ? 4'h1 : 4'hf, DIV ? 3'd3 : 3'd0);
    exe(1'b0, 1'b0, 3'b000, 8'h00, 8'h51);
    st2("ovf_hold", 8'h52, DIV ? 4'h3 : 4'hf, DIV ? 2'd2 : 2'd0, DIV);
    rst();
    st2("ovf_reset", 8'h00, 4'hf, 2'd0, 1'b0);
    te = 4'b0011;
    set_nzp(32'h01010404);
    exe(1'b1, 1'b0, 3'b100, 8'h70, 8'h08);
    st4("partial", 8'h70, 4'hf, 3'd0);
    te = 4'b0000;
    exe(1'b1, 1'b0, 3'b100, 8'h22, 8'h70);
    st4("eff_zero", DIV ? 8'h22 : 8'h71, 4'hf, 3'd0);
    te = 4'hf;
    rst();
    set_nzp(32'h01010404);
    exe(1'b1, 1'b0, 3'b100, 8'h30, 8'h10);
    exe(1'b1, 1'b1, 3'b100, 8'h38, 8'h30);
    st4("mux_and_sync", DIV ? 8'h38 : 8'h31, DIV ? 4'h3 : 4'hf, DIV ? 3'd1 : 3'd0);
    rst();
    st4("mid_reset", 8'h00, 4'hf, 3'd0);
    chk("mid_reset_ovf", 32'(b4.stack_overflow), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
